// File: rtl/proc_control_fsm_if.sv
// Control bundle between proc_control_fsm and the 16-bit datapath.
// master: the control FSM. slave: the datapath (or a bench standing in for it).
// The retired_cnt signal exists only when INSTR_COUNT_EN is defined.
interface proc_control_fsm_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 3
);
  logic              run;
  logic [DATA_W-1:0] instr;
  logic [DATA_W-1:0] imm;
  logic              din_sel;
  logic              wb_sel;
  logic [REG_AW-1:0] rx_addr;
  logic [REG_AW-1:0] ry_addr;
  logic              rd_sel;
  logic              reg_we;
  logic              a_load;
  logic              g_load;
  logic [1:0]        alu_op;
  logic              ir_load;
  logic              busy;
  logic              done;
  logic              illegal;
`ifdef INSTR_COUNT_EN
  logic [DATA_W-1:0] retired_cnt;

  modport master (
    input  run, instr,
    output imm, din_sel, wb_sel, rx_addr, ry_addr, rd_sel, reg_we, a_load, g_load,
    output alu_op, ir_load, busy, done, illegal, retired_cnt
  );

  modport slave (
    output run, instr,
    input  imm, din_sel, wb_sel, rx_addr, ry_addr, rd_sel, reg_we, a_load, g_load,
    input  alu_op, ir_load, busy, done, illegal, retired_cnt
  );
`else
  modport master (
    input  run, instr,
    output imm, din_sel, wb_sel, rx_addr, ry_addr, rd_sel, reg_we, a_load, g_load,
    output alu_op, ir_load, busy, done, illegal
  );

  modport slave (
    output run, instr,
    input  imm, din_sel, wb_sel, rx_addr, ry_addr, rd_sel, reg_we, a_load, g_load,
    input  alu_op, ir_load, busy, done, illegal
  );
`endif
endinterface

// File: rtl/proc_control_fsm.sv
// Multi-cycle control unit for the 16-bit datapath: fetch, decode, execute, write-back.
// Drives the data/write-back/address mux selects and the register, A, G and IR enables.
// Optional feature: define INSTR_COUNT_EN to add the retired_cnt instruction counter.
module proc_control_fsm #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 3
) (
  input logic                clk,
  input logic                reset,
  proc_control_fsm_if.master bus
);

  localparam logic [3:0] OpMv  = 4'd0;
  localparam logic [3:0] OpMvi = 4'd1;
  localparam logic [3:0] OpAdd = 4'd2;
  localparam logic [3:0] OpSub = 4'd3;
  localparam logic [3:0] OpAnd = 4'd4;
  localparam logic [3:0] OpOr  = 4'd5;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StMove,
    StExA,
    StExG,
    StWb,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] ir_q;
  logic              ill_q, ill_d;

  // Instruction fields, all combinational from IR
  logic [3:0]        opcode;
  logic              op_is_move;
  logic              op_is_alu;
  logic [1:0]        alu_code;

  assign opcode      = ir_q[15:12];
  assign bus.rx_addr = ir_q[9 +: REG_AW];
  assign bus.ry_addr = ir_q[6 +: REG_AW];
  assign bus.imm     = {{(DATA_W-9){1'b0}}, ir_q[8:0]};

  assign op_is_move = (opcode == OpMv) || (opcode == OpMvi);
  assign op_is_alu  = (opcode == OpAdd) || (opcode == OpSub) ||
                      (opcode == OpAnd) || (opcode == OpOr);
  // ADD..OR are opcodes 2..5; subtracting 2 in the low bits maps them to 00..11
  assign alu_code   = opcode[1:0] - 2'd2;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Instruction register, loaded only in FETCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q <= '0;
    end else if (bus.ir_load) begin
      ir_q <= bus.instr;
    end
  end

  // Illegal-opcode flag, set in DECODE and held until DONE is left
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ill_q <= 1'b0;
    end else begin
      ill_q <= ill_d;
    end
  end

  // Next-state and Moore outputs; every output defaults to 0
  always_comb begin
    state_d     = state_q;
    ill_d       = ill_q;
    bus.din_sel = 1'b0;
    bus.wb_sel  = 1'b0;
    bus.rd_sel  = 1'b0;
    bus.reg_we  = 1'b0;
    bus.a_load  = 1'b0;
    bus.g_load  = 1'b0;
    bus.alu_op  = 2'b00;
    bus.ir_load = 1'b0;
    bus.busy    = 1'b1;
    bus.done    = 1'b0;
    bus.illegal = 1'b0;

    unique case (state_q)
      StIdle: begin
        bus.busy = 1'b0;
        if (bus.run) begin
          state_d = StFetch;
        end
      end

      StFetch: begin
        bus.ir_load = 1'b1;
        state_d     = StDecode;
      end

      StDecode: begin
        if (op_is_move) begin
          state_d = StMove;
        end else if (op_is_alu) begin
          state_d = StExA;
        end else begin
          ill_d   = 1'b1;
          state_d = StDone;
        end
      end

      StMove: begin
        bus.reg_we = 1'b1;
        bus.wb_sel = 1'b0;
        if (opcode == OpMvi) begin
          bus.din_sel = 1'b1;
        end else begin
          bus.rd_sel  = 1'b1;
          bus.din_sel = 1'b0;
        end
        state_d = StDone;
      end

      // A captures Rx here, so Rx==Ry still sees the original Rx value
      StExA: begin
        bus.rd_sel  = 1'b0;
        bus.din_sel = 1'b0;
        bus.a_load  = 1'b1;
        state_d     = StExG;
      end

      StExG: begin
        bus.rd_sel  = 1'b1;
        bus.din_sel = 1'b0;
        bus.g_load  = 1'b1;
        bus.alu_op  = alu_code;
        state_d     = StWb;
      end

      StWb: begin
        bus.wb_sel = 1'b1;
        bus.reg_we = 1'b1;
        state_d    = StDone;
      end

      StDone: begin
        bus.done    = 1'b1;
        bus.illegal = ill_q;
        ill_d       = 1'b0;
        state_d     = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

`ifdef INSTR_COUNT_EN
  logic [DATA_W-1:0] retired_q;

  // Count legal retirements; wraps naturally at the top of the range
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_q <= '0;
    end else if ((state_q == StDone) && !ill_q) begin
      retired_q <= retired_q + DATA_W'(1);
    end
  end

  assign bus.retired_cnt = retired_q;
`endif

endmodule

// File: tb/tb_proc_control_fsm.sv
// Directed self-checking bench for proc_control_fsm.
// Control outputs are packed into one word per cycle and compared with hand-built traces:
// [11] ir_load [10] din_sel [9] wb_sel [8] rd_sel [7] reg_we [6] a_load [5] g_load
// [4:3] alu_op [2] busy [1] done [0] illegal
module tb_proc_control_fsm;

  logic clk = 1'b0;
  logic reset;
  int unsigned err_cnt = 0;
  int unsigned chk_cnt = 0;
  int unsigned n_legal = 0;

  proc_control_fsm_if #(.DATA_W(16), .REG_AW(3)) bus_if ();

  proc_control_fsm #(.DATA_W(16), .REG_AW(3)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if.master)
  );

  always #5 clk = ~clk;

  logic [11:0] ctl;
  assign ctl = {bus_if.ir_load, bus_if.din_sel, bus_if.wb_sel, bus_if.rd_sel, bus_if.reg_we,
                bus_if.a_load, bus_if.g_load, bus_if.alu_op, bus_if.busy, bus_if.done,
                bus_if.illegal};

  logic [11:0] exp_trace[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT in IDLE; compares each cycle against exp_trace
  task automatic run_trace(input string name, input logic [15:0] word);
    check($sformatf("%s idle0", name), 32'(ctl), 32'h0);
    bus_if.run   = 1'b1;
    bus_if.instr = word;
    @(negedge clk);
    bus_if.run = 1'b0;
    for (int i = 0; i < exp_trace.size(); i++) begin
      check($sformatf("%s c%0d", name, i + 1), 32'(ctl), 32'(exp_trace[i]));
      // instr only needs to be valid during FETCH
      if (i == 1) bus_if.instr = ~word;
      @(negedge clk);
    end
    check($sformatf("%s idle_after", name), 32'(ctl), 32'h0);
  endtask

  initial begin
    logic [11:0] acc;
    int n_ir, ir2, n_done, done1, done2;

    reset        = 1'b1;
    bus_if.run   = 1'b0;
    bus_if.instr = 16'h0;
    repeat (2) @(negedge clk);
    check("reset ctl", 32'(ctl), 32'h0);
    check("reset rx_addr", 32'(bus_if.rx_addr), 32'h0);
    check("reset imm", 32'(bus_if.imm), 32'h0);
`ifdef INSTR_COUNT_EN
    check("reset retired_cnt", 32'(bus_if.retired_cnt), 32'h0);
`endif
    reset = 1'b0;
    @(negedge clk);

    // ADD R1,R2 interrupted by reset in EXG
    bus_if.run   = 1'b1;
    bus_if.instr = 16'h2280;
    @(negedge clk);
    bus_if.run = 1'b0;
    repeat (3) @(negedge clk);
    check("abort in EXG", 32'(ctl), 32'h124);
    reset = 1'b1;
    #1;
    check("abort async ctl", 32'(ctl), 32'h0);
    check("abort IR cleared", 32'(bus_if.rx_addr), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    acc = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      acc = acc | ctl;
    end
    check("idle 10 cycles", 32'(acc), 32'h0);

    // MVI R3,#0x1A5
    exp_trace = {12'h804, 12'h004, 12'h484, 12'h006};
    run_trace("MVI", 16'h17A5);
    check("MVI rx_addr", 32'(bus_if.rx_addr), 32'd3);
    check("MVI ry_addr", 32'(bus_if.ry_addr), 32'd6);
    check("MVI imm", 32'(bus_if.imm), 32'h01A5);
    n_legal++;

    // ADD R1,R2
    exp_trace = {12'h804, 12'h004, 12'h044, 12'h124, 12'h284, 12'h006};
    run_trace("ADD", 16'h2280);
    check("ADD rx_addr", 32'(bus_if.rx_addr), 32'd1);
    check("ADD ry_addr", 32'(bus_if.ry_addr), 32'd2);
    n_legal++;

    // SUB R1,R2
    exp_trace = {12'h804, 12'h004, 12'h044, 12'h12C, 12'h284, 12'h006};
    run_trace("SUB", 16'h3280);
    n_legal++;

    // Opcode 0xF: done and illegal together, no enables
    exp_trace = {12'h804, 12'h004, 12'h007};
    run_trace("ILL_F", 16'hF000);

`ifdef INSTR_COUNT_EN
    check("retired after 3+1", 32'(bus_if.retired_cnt), 32'd3);
`endif

    exp_trace = {12'h804, 12'h004, 12'h044, 12'h134, 12'h284, 12'h006};
    run_trace("AND", 16'h4280);
    n_legal++;

    exp_trace = {12'h804, 12'h004, 12'h044, 12'h13C, 12'h284, 12'h006};
    run_trace("OR", 16'h5280);
    n_legal++;

    // ADD R2,R2
    exp_trace = {12'h804, 12'h004, 12'h044, 12'h124, 12'h284, 12'h006};
    run_trace("ADD_RR", 16'h2480);
    check("ADD_RR rx_addr", 32'(bus_if.rx_addr), 32'd2);
    check("ADD_RR ry_addr", 32'(bus_if.ry_addr), 32'd2);
    n_legal++;

    exp_trace = {12'h804, 12'h004, 12'h007};
    run_trace("ILL_6", 16'h6000);

    // MV R4,R5
    exp_trace = {12'h804, 12'h004, 12'h184, 12'h006};
    run_trace("MV", 16'h0940);
    check("MV rx_addr", 32'(bus_if.rx_addr), 32'd4);
    check("MV ry_addr", 32'(bus_if.ry_addr), 32'd5);
    n_legal++;

    // run held high across two MV instructions
    n_ir = 0; ir2 = 0; n_done = 0; done1 = 0; done2 = 0;
    bus_if.run   = 1'b1;
    bus_if.instr = 16'h0940;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      if (ctl[11]) begin
        n_ir++;
        if (n_ir == 2) ir2 = c;
      end
      if (ctl[1]) begin
        n_done++;
        if (n_done == 1) done1 = c;
        if (n_done == 2) done2 = c;
      end
      if (c == 9) bus_if.run = 1'b0;
    end
    check("held run fetches", 32'(n_ir), 32'd2);
    check("held run done1", 32'(done1), 32'd4);
    check("held run second fetch", 32'(ir2), 32'd6);
    check("held run done2", 32'(done2), 32'd9);
    n_legal += 2;

    // run toggling while busy must not start extra fetches
    n_ir = 0; n_done = 0; done1 = 0;
    bus_if.run   = 1'b1;
    bus_if.instr = 16'h2280;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (ctl[11]) n_ir++;
      if (ctl[1]) begin
        n_done++;
        if (n_done == 1) done1 = c;
      end
      bus_if.run = (c < 6) ? 1'(c % 2) : 1'b0;
    end
    check("toggle run fetches", 32'(n_ir), 32'd1);
    check("toggle run done", 32'(done1), 32'd6);
    n_legal++;

`ifdef INSTR_COUNT_EN
    check("retired total", 32'(bus_if.retired_cnt), 32'(n_legal));
    force dut.retired_q = 16'hFFFF;
    #1;
    release dut.retired_q;
    check("retired preload", 32'(bus_if.retired_cnt), 32'hFFFF);
    exp_trace = {12'h804, 12'h004, 12'h184, 12'h006};
    run_trace("MV_wrap", 16'h0940);
    check("retired wrap", 32'(bus_if.retired_cnt), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
